program_encoder: RTL and testbench
==================================

PROGRAM_ENCODER -- requirements
Module: program_encoder

Interface
REQ-001: Parameter ADDR_W, default 8, sets the instruction-memory word-address width (DEPTH = 2^ADDR_W words).
REQ-002: clk  input  1  single clock; all state updates on the rising edge.
REQ-003: rst_n  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  single-cycle pulse that opens a program-load session.
REQ-005: cmd_valid  input  1  command present.
REQ-006: cmd_ready  output  1  encoder accepts the command this cycle.
REQ-007: cmd_kind  input  3  command code: 0 R_TYPE, 1 LW, 2 SW, 3 BEQ, 4 ADDI, 5 JMP, 6 END, 7 illegal.
REQ-008: cmd_rs, cmd_rt, cmd_rd, cmd_shamt  input  5 each  register and shift fields.
REQ-009: cmd_funct  input  6  R_TYPE function field.
REQ-010: cmd_imm  input  16  I-type immediate.
REQ-011: cmd_target  input  26  J-type target.
REQ-012: imem_we  output  1  instruction-memory write strobe.
REQ-013: imem_addr  output  ADDR_W  word address of the write.
REQ-014: imem_wdata  output  32  encoded instruction word.
REQ-015: busy  output  1  session in progress.
REQ-016: done  output  1  one-cycle pulse when the HALT word is written.
REQ-017: err  output  1  sticky error flag, cleared only by start or reset.

Function
REQ-018: FSM states are IDLE, ACCEPT, WRITE, and DONE; reset enters IDLE.
REQ-019: IDLE -> ACCEPT on start, with the address counter cleared to 0 and err cleared; busy is 1 in every state except IDLE.
REQ-020: In ACCEPT, cmd_ready is 1 and a transfer occurs when cmd_valid and cmd_ready are both 1; cmd_ready is 0 in all other states.
REQ-021: A transfer registers the encoded word and moves to WRITE.
REQ-022: In WRITE, imem_we = 1 for exactly one cycle with imem_addr = counter, so the write occurs on the cycle after acceptance (latency 1).
REQ-023: After the write, the counter increments and the FSM returns to ACCEPT, or goes to DONE if the written word was HALT.
REQ-024: Opcode bits [31:26]: R_TYPE 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, JMP 000010, END 111111.
REQ-025: R_TYPE encodes as {op, rs, rt, rd, shamt, funct}.
REQ-026: LW, SW, BEQ, and ADDI encode as {op, rs, rt, imm}.
REQ-027: JMP encodes as {op, target}.
REQ-028: END encodes as {111111, 26'b0}; fields not used by a kind are ignored.
REQ-029: An illegal kind (7) is accepted (handshake completes), writes nothing, sets err, and the FSM stays in ACCEPT.
REQ-030: Full condition: when the counter equals DEPTH-1, the next accepted command is encoded as the HALT word regardless of kind, and err is set if that kind was not END.
REQ-031: The counter never wraps.
REQ-032: DONE asserts done for one cycle and then goes to IDLE; imem_addr holds its last value.
REQ-033: start received while busy is ignored.
REQ-034: imem_wdata is don't-care when imem_we is 0 but shall be registered, never combinational from cmd_*.

Reset
REQ-035: On rst_n = 0 at any time, including mid-session, the FSM goes to IDLE immediately.
REQ-036: During reset, imem_we, cmd_ready, busy, done, and err are all 0, imem_addr is 0, and imem_wdata is 0.
REQ-037: No write is issued on the first clock after reset release.

Verification
REQ-038: Encoding check.
- Stimulus: start; then LW rs=2 rt=3 imm=0x0010; then END.
- Required response: imem writes 0x8C430010 at address 0 and 0xFC000000 at address 1; done pulses once; busy returns to 0.
REQ-039: R_TYPE and JMP encoding.
- Stimulus: R_TYPE rs=1 rt=2 rd=3 shamt=0 funct=0x20; then JMP target=0x0000040.
- Required response: 0x00221820 at address 0 and 0x08000040 at address 1.
REQ-040: Backpressure.
- Stimulus: cmd_valid held high for 4 commands.
- Required response: cmd_ready toggles 1,0,1,0; exactly one imem_we per accepted command; addresses 0,1,2,3.
REQ-041: Illegal kind.
- Stimulus: kind 7, then ADDI rs=0 rt=8 imm=0xFFFF.
- Required response: err = 1; no write for kind 7; 0x2008FFFF written at address 0.
REQ-042: Full memory.
- Stimulus: ADDR_W = 2; send 4 ADDI commands.
- Required response: the 4th command is written as 0xFC000000 at address 3; err = 1; done pulses.
REQ-043: Reset mid-session.
- Stimulus: assert rst_n = 0 while in WRITE.
- Required response: imem_we drops to 0 in the same cycle; all outputs are 0; start after release writes at address 0.

Source files
------------

// File: rtl/program_encoder.sv
// Program encoder: turns a stream of assembler-level commands into 32-bit
// MIPS-style instruction words and writes them to instruction memory.
module program_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [5:0]        cmd_funct,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCEPT = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [2:0] K_RTYPE = 3'd0;
    localparam logic [2:0] K_LW    = 3'd1;
    localparam logic [2:0] K_SW    = 3'd2;
    localparam logic [2:0] K_BEQ   = 3'd3;
    localparam logic [2:0] K_ADDI  = 3'd4;
    localparam logic [2:0] K_JMP   = 3'd5;
    localparam logic [2:0] K_END   = 3'd6;

    localparam logic [ADDR_W-1:0] LAST = '1;
    localparam logic [31:0]       HALT = 32'hFC00_0000;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              halt_q, halt_d;
    logic              err_q, err_d;

    logic [31:0] enc_word;
    logic        illegal;
    logic        full;

    always_comb begin
        enc_word = 32'd0;
        illegal  = 1'b0;
        case (cmd_kind)
            K_RTYPE: enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd,
                                 cmd_shamt, cmd_funct};
            K_LW:    enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
            K_SW:    enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
            K_BEQ:   enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
            K_ADDI:  enc_word = {6'b001000, cmd_rs, cmd_rt, cmd_imm};
            K_JMP:   enc_word = {6'b000010, cmd_target};
            K_END:   enc_word = HALT;
            default: illegal  = 1'b1;
        endcase
    end

    assign full = (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        halt_d  = halt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCEPT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_ACCEPT: begin
                if (cmd_valid) begin
                    // The last slot always receives HALT so a program is terminated.
                    if (illegal && !full) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                        halt_d  = full || (cmd_kind == K_END);
                        wdata_d = (full || cmd_kind == K_END) ? HALT : enc_word;
                        if (full && cmd_kind != K_END)
                            err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (halt_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ACCEPT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wdata_q <= 32'd0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready  = (state_q == S_ACCEPT);
    assign imem_we    = (state_q == S_WRITE);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign imem_addr  = cnt_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_program_encoder.sv
// Self-checking bench for program_encoder: scoreboard of expected memory
// writes, one default-width instance and one ADDR_W=2 instance.
module tb_program_encoder;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st8 = 1'b0, st2 = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  kind = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, sh = '0;
    logic [5:0]  fn = '0;
    logic [15:0] imm = '0;
    logic [25:0] tgt = '0;

    logic        rdy8, we8, busy8, done8, err8;
    logic [7:0]  addr8;
    logic [31:0] wd8;
    logic        rdy2, we2, busy2, done2, err2;
    logic [1:0]  addr2;
    logic [31:0] wd2;

    int   n_tests = 0, n_fail = 0;
    int   dn8 = 0, dn2 = 0;
    exp_t q8[$], q2[$];

    always #5 clk = ~clk;

    program_encoder #(.ADDR_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .cmd_valid(valid),
        .cmd_ready(rdy8), .cmd_kind(kind), .cmd_rs(rs), .cmd_rt(rt),
        .cmd_rd(rd), .cmd_shamt(sh), .cmd_funct(fn), .cmd_imm(imm),
        .cmd_target(tgt), .imem_we(we8), .imem_addr(addr8),
        .imem_wdata(wd8), .busy(busy8), .done(done8), .err(err8)
    );

    program_encoder #(.ADDR_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .cmd_valid(valid),
        .cmd_ready(rdy2), .cmd_kind(kind), .cmd_rs(rs), .cmd_rt(rt),
        .cmd_rd(rd), .cmd_shamt(sh), .cmd_funct(fn), .cmd_imm(imm),
        .cmd_target(tgt), .imem_we(we2), .imem_addr(addr2),
        .imem_wdata(wd2), .busy(busy2), .done(done2), .err(err2)
    );

    function automatic logic [31:0] enc(
        input logic [2:0] k, input logic [4:0] a, b, c, d,
        input logic [5:0] f, input logic [15:0] im, input logic [25:0] tg);
        case (k)
            3'd0: return {6'h00, a, b, c, d, f};
            3'd1: return {6'h23, a, b, im};
            3'd2: return {6'h2B, a, b, im};
            3'd3: return {6'h04, a, b, im};
            3'd4: return {6'h08, a, b, im};
            3'd5: return {6'h02, tg};
            default: return 32'hFC00_0000;
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (we8) begin
            n_tests++;
            if (q8.size() == 0) begin
                n_fail++;
                $display("FAIL wr8_unexpected: got addr=%0d data=%h, expected no write",
                         addr8, wd8);
            end else begin
                e = q8.pop_front();
                if (addr8 !== 8'(e.addr) || wd8 !== e.data) begin
                    n_fail++;
                    $display("FAIL wr8: got addr=%0d data=%h, expected addr=%0d data=%h",
                             addr8, wd8, e.addr, e.data);
                end
            end
        end
        if (we2) begin
            n_tests++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL wr2_unexpected: got addr=%0d data=%h, expected no write",
                         addr2, wd2);
            end else begin
                e = q2.pop_front();
                if (addr2 !== 2'(e.addr) || wd2 !== e.data) begin
                    n_fail++;
                    $display("FAIL wr2: got addr=%0d data=%h, expected addr=%0d data=%h",
                             addr2, wd2, e.addr, e.data);
                end
            end
        end
        if (done8) dn8++;
        if (done2) dn2++;
    end

    task automatic do_start(input int sel);
        @(negedge clk);
        if (sel == 1) st2 = 1'b1;
        else st8 = 1'b1;
        @(posedge clk);
        #1;
        st8 = 1'b0;
        st2 = 1'b0;
    endtask

    task automatic send(input int sel, input logic [2:0] k,
                        input logic [4:0] a, b, c, d, input logic [5:0] f,
                        input logic [15:0] im, input logic [25:0] tg,
                        input bit wr, input int ea, input logic [31:0] ew);
        exp_t e;
        int   n;
        kind = k; rs = a; rt = b; rd = c; sh = d; fn = f; imm = im; tgt = tg;
        if (wr) begin
            e.addr = ea;
            e.data = ew;
            if (sel == 1) q2.push_back(e);
            else q8.push_back(e);
        end
        valid = 1'b1;
        for (n = 0; n < 30; n++) begin
            if ((sel == 1 ? rdy2 : rdy8) === 1'b1) break;
            @(negedge clk);
        end
        if (n == 30) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got cmd_ready=0 for 30 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int last_addr);
        int n;
        int base;
        base = (sel == 1) ? dn2 : dn8;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if ((sel == 1 ? done2 : done8) === 1'b1) break;
        end
        n_tests++;
        if (n == 30) begin
            n_fail++;
            $display("FAIL done_timeout: got done=0 for 30 cycles, expected pulse");
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (((sel == 1 ? dn2 : dn8) - base) != 1) begin
            n_fail++;
            $display("FAIL done_count: got %0d pulses, expected 1",
                     (sel == 1 ? dn2 : dn8) - base);
        end
        n_tests++;
        if ((sel == 1 ? busy2 : busy8) !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_done: got 1, expected 0");
        end
        n_tests++;
        if ((sel == 1 ? int'(addr2) : int'(addr8)) != last_addr) begin
            n_fail++;
            $display("FAIL addr_hold: got %0d, expected %0d",
                     (sel == 1 ? int'(addr2) : int'(addr8)), last_addr);
        end
    endtask

    task automatic check_drained(input string name);
        n_tests++;
        if (q8.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: got %0d/%0d pending writes, expected 0/0",
                     name, q8.size(), q2.size());
            q8.delete();
            q2.delete();
        end
    endtask

    task automatic check_outs_zero(input string name);
        n_tests++;
        if ({we8, rdy8, busy8, done8, err8} !== 5'b0 || addr8 !== 8'd0 ||
            wd8 !== 32'd0 || {we2, rdy2, busy2, done2, err2} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s: got we/rdy/busy/done/err=%b addr=%0d wdata=%h, expected all 0",
                     name, {we8, rdy8, busy8, done8, err8}, addr8, wd8);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        check_outs_zero("reset_state");
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy8 !== 1'b0 || we8 !== 1'b0) begin
            n_fail++;
            $display("FAIL post_release: got busy=%b we=%b, expected 0 0", busy8, we8);
        end
    endtask

    task automatic test_encoding;
        do_start(0);
        send(0, 3'd1, 5'd2, 5'd3, 0, 0, 0, 16'h0010, 0, 1, 0, 32'h8C43_0010);
        send(0, 3'd6, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hABCD, 26'h1,
             1, 1, 32'hFC00_0000);
        wait_done(0, 1);
        check_drained("encoding");
    endtask

    task automatic test_illegal;
        do_start(0);
        send(0, 3'd7, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1, 0, 0, 0);
        send(0, 3'd4, 5'd0, 5'd8, 0, 0, 0, 16'hFFFF, 0, 1, 0, 32'h2008_FFFF);
        @(negedge clk);
        n_tests++;
        if (err8 !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err: got %b, expected 1", err8);
        end
        send(0, 3'd6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFC00_0000);
        wait_done(0, 1);
        n_tests++;
        if (err8 !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_err_sticky: got %b, expected 1", err8);
        end
        check_drained("illegal");
    endtask

    task automatic test_rtype_jmp;
        do_start(0);
        n_tests++;
        if (err8 !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears_err: got %b, expected 0", err8);
        end
        send(0, 3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h7777, 26'h3,
             1, 0, enc(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h7777, 26'h3));
        do_start(0);
        send(0, 3'd5, 5'd7, 5'd7, 5'd7, 5'd7, 6'h7, 16'h7, 26'h0000040,
             1, 1, 32'h0800_0040);
        send(0, 3'd2, 5'd31, 5'd17, 0, 0, 0, 16'h8001, 0,
             1, 2, enc(3'd2, 5'd31, 5'd17, 0, 0, 0, 16'h8001, 0));
        send(0, 3'd3, 5'd4, 5'd5, 0, 0, 0, 16'hFFFE, 0,
             1, 3, enc(3'd3, 5'd4, 5'd5, 0, 0, 0, 16'hFFFE, 0));
        send(0, 3'd6, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hFC00_0000);
        wait_done(0, 4);
        check_drained("rtype_jmp");
    endtask

    task automatic test_back_to_back;
        exp_t e;
        do_start(0);
        valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (rdy8 !== ((i % 2) == 0)) begin
                n_fail++;
                $display("FAIL bp_ready[%0d]: got %b, expected %b", i, rdy8, (i % 2) == 0);
            end
            if ((i % 2) == 0) begin
                kind = 3'd4; rs = 5'(i); rt = 5'(i + 1); imm = 16'(16'h100 + i);
                e.addr = i / 2;
                e.data = enc(3'd4, 5'(i), 5'(i + 1), 0, 0, 0, 16'(16'h100 + i), 0);
                q8.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        send(0, 3'd6, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'hFC00_0000);
        wait_done(0, 4);
        check_drained("back_to_back");
    endtask

    task automatic test_full;
        do_start(1);
        for (int i = 0; i < 3; i++)
            send(1, 3'd4, 5'd1, 5'(i), 0, 0, 0, 16'(i + 5), 0,
                 1, i, enc(3'd4, 5'd1, 5'(i), 0, 0, 0, 16'(i + 5), 0));
        send(1, 3'd4, 5'd1, 5'd3, 0, 0, 0, 16'd8, 0, 1, 3, 32'hFC00_0000);
        wait_done(1, 3);
        n_tests++;
        if (err2 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_err: got %b, expected 1", err2);
        end
        check_drained("full");
    endtask

    task automatic test_reset_mid;
        do_start(0);
        send(0, 3'd4, 5'd2, 5'd2, 0, 0, 0, 16'h0042, 0,
             1, 0, enc(3'd4, 5'd2, 5'd2, 0, 0, 0, 16'h0042, 0));
        send(0, 3'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        send(0, 3'd1, 5'd1, 5'd1, 0, 0, 0, 16'h1, 0, 0, 0, 0);
        n_tests++;
        if (we8 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_in_write: got we=%b, expected 1", we8);
        end
        #2 rst_n = 1'b0;
        #1;
        check_outs_zero("mid_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_start(0);
        send(0, 3'd4, 5'd0, 5'd8, 0, 0, 0, 16'hFFFF, 0, 1, 0, 32'h2008_FFFF);
        send(0, 3'd6, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'hFC00_0000);
        wait_done(0, 1);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_illegal();
        test_rtype_jmp();
        test_back_to_back();
        test_full();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
